// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared types and constants for the LEGv8 MEM stage
package legv8_pkg;

    localparam int LEGV8_DATA_W  = 64;
    localparam int LEGV8_WR_W    = 5;
    localparam int LEGV8_TIMEOUT = 16;

    // Doubleword accesses must be 8-byte aligned
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    function automatic logic is_aligned(input logic [2:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 3'b000;
    endfunction

endpackage

// File: rtl/dmem_handshake.sv
// rtl/dmem_handshake.sv - request FSM and timeout counter for the data memory port
module dmem_handshake
    import legv8_pkg::*;
#(
    parameter int TIMEOUT = LEGV8_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic dmem_ready,
    output logic busy,
    output logic done,
    output logic timeout_fire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Completion terms depend only on state, counter and ready so the
    // start path from the stage (which uses them) cannot loop back here.
    assign busy         = (state_q == REQ);
    assign done         = busy & dmem_ready;
    assign timeout_fire = busy & ~dmem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and wait-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a back-to-back memory op re-enters REQ on the completing edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (done || timeout_fire) begin
                    state_d = start ? REQ : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LEGv8 MEM stage: EX/MEM register, data memory handshake, MEM/WB register
module mem_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W  = LEGV8_DATA_W,
    parameter int WR_W    = LEGV8_WR_W,
    parameter int TIMEOUT = LEGV8_TIMEOUT
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] RD2_s4,
    input  logic [DATA_W-1:0] AddBranch_s4,
    input  logic              RegWrite_s4,
    input  logic              MemtoReg_s4,
    input  logic              Branch_s4,
    input  logic              MemRead_s4,
    input  logic              MemWrite_s4,
    input  logic [WR_W-1:0]   WR_s4,
    output logic              ex_stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] BranchTarget,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] ReadData_s5,
    output logic [DATA_W-1:0] ALUResult_s5,
    output logic [WR_W-1:0]   WR_s5,
    output logic              RegWrite_s5,
    output logic              MemtoReg_s5,
    output logic              mem_err
);

    // EX/MEM register
    logic              exm_valid_q, exm_valid_d;
    logic [DATA_W-1:0] exm_alu_q, exm_alu_d;
    logic              exm_zero_q, exm_zero_d;
    logic [DATA_W-1:0] exm_rd2_q, exm_rd2_d;
    logic [DATA_W-1:0] exm_addb_q, exm_addb_d;
    logic              exm_rw_q, exm_rw_d;
    logic              exm_m2r_q, exm_m2r_d;
    logic              exm_br_q, exm_br_d;
    logic              exm_mr_q, exm_mr_d;
    logic              exm_mw_q, exm_mw_d;
    logic [WR_W-1:0]   exm_wr_q, exm_wr_d;

    // MEM/WB register
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [WR_W-1:0]   wb_wr_q, wb_wr_d;
    logic              wb_rw_q, wb_rw_d;
    logic              wb_m2r_q, wb_m2r_d;
    logic              wb_err_q, wb_err_d;

    logic busy, done, timeout_fire, start;
    logic exm_mem_op, exm_misaligned;

    // An aligned memory op entering EX/MEM starts the request on the same edge,
    // so dmem_req is purely registered and the first REQ cycle can already complete.
    assign start = ~ex_stall & ex_valid & (MemRead_s4 | MemWrite_s4)
                 & is_aligned(ALUResult[2:0]);

    assign exm_mem_op     = exm_valid_q & (exm_mr_q | exm_mw_q);
    assign exm_misaligned = exm_mem_op & ~is_aligned(exm_alu_q[2:0]);

    // Combinational from dmem_ready on purpose: completion releases EXE in the same cycle
    assign ex_stall = busy & ~(done | timeout_fire);

    dmem_handshake #(
        .TIMEOUT(TIMEOUT)
    ) u_hs (
        .clk         (CLK),
        .rst_n       (rst_n),
        .start       (start),
        .dmem_ready  (dmem_ready),
        .busy        (busy),
        .done        (done),
        .timeout_fire(timeout_fire)
    );

    assign dmem_req     = busy;
    assign dmem_we      = exm_mw_q;
    assign dmem_addr    = exm_alu_q;
    assign dmem_wdata   = exm_rd2_q;
    assign PCSrc        = exm_valid_q & exm_br_q & exm_zero_q;
    assign BranchTarget = exm_addb_q;

    assign wb_valid     = wb_valid_q;
    assign ReadData_s5  = wb_rd_q;
    assign ALUResult_s5 = wb_alu_q;
    assign WR_s5        = wb_wr_q;
    assign RegWrite_s5  = wb_rw_q;
    assign MemtoReg_s5  = wb_m2r_q;
    assign mem_err      = wb_err_q;

    // EX/MEM next value: hold while stalled, a captured bubble clears all control
    always_comb begin
        exm_valid_d = exm_valid_q;
        exm_alu_d   = exm_alu_q;
        exm_zero_d  = exm_zero_q;
        exm_rd2_d   = exm_rd2_q;
        exm_addb_d  = exm_addb_q;
        exm_rw_d    = exm_rw_q;
        exm_m2r_d   = exm_m2r_q;
        exm_br_d    = exm_br_q;
        exm_mr_d    = exm_mr_q;
        exm_mw_d    = exm_mw_q;
        exm_wr_d    = exm_wr_q;
        if (!ex_stall) begin
            exm_valid_d = ex_valid;
            exm_alu_d   = ALUResult;
            exm_zero_d  = Zero;
            exm_rd2_d   = RD2_s4;
            exm_addb_d  = AddBranch_s4;
            exm_rw_d    = ex_valid & RegWrite_s4;
            exm_m2r_d   = ex_valid & MemtoReg_s4;
            exm_br_d    = ex_valid & Branch_s4;
            exm_mr_d    = ex_valid & MemRead_s4;
            exm_mw_d    = ex_valid & MemWrite_s4;
            exm_wr_d    = WR_s4;
        end
    end

    // MEM/WB next value: bubble while an access waits, retire once on done/timeout
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rd_d    = '0;
        wb_alu_d   = '0;
        wb_wr_d    = '0;
        wb_rw_d    = 1'b0;
        wb_m2r_d   = 1'b0;
        wb_err_d   = 1'b0;
        if (busy) begin
            if (done || timeout_fire) begin
                wb_valid_d = 1'b1;
                wb_alu_d   = exm_alu_q;
                wb_wr_d    = exm_wr_q;
                wb_m2r_d   = exm_m2r_q;
                if (done) begin
                    wb_rw_d = exm_rw_q;
                    wb_rd_d = (exm_mr_q & ~exm_mw_q) ? dmem_rdata : '0;
                end else begin
                    wb_err_d = 1'b1;
                end
            end
        end else if (exm_valid_q) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = exm_alu_q;
            wb_wr_d    = exm_wr_q;
            wb_m2r_d   = exm_m2r_q;
            wb_rw_d    = exm_rw_q & ~exm_misaligned;
            wb_err_d   = exm_misaligned;
        end
    end

    // EX/MEM register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q <= 1'b0;
            exm_alu_q   <= '0;
            exm_zero_q  <= 1'b0;
            exm_rd2_q   <= '0;
            exm_addb_q  <= '0;
            exm_rw_q    <= 1'b0;
            exm_m2r_q   <= 1'b0;
            exm_br_q    <= 1'b0;
            exm_mr_q    <= 1'b0;
            exm_mw_q    <= 1'b0;
            exm_wr_q    <= '0;
        end else begin
            exm_valid_q <= exm_valid_d;
            exm_alu_q   <= exm_alu_d;
            exm_zero_q  <= exm_zero_d;
            exm_rd2_q   <= exm_rd2_d;
            exm_addb_q  <= exm_addb_d;
            exm_rw_q    <= exm_rw_d;
            exm_m2r_q   <= exm_m2r_d;
            exm_br_q    <= exm_br_d;
            exm_mr_q    <= exm_mr_d;
            exm_mw_q    <= exm_mw_d;
            exm_wr_q    <= exm_wr_d;
        end
    end

    // MEM/WB register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_alu_q   <= '0;
            wb_wr_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_alu_q   <= wb_alu_d;
            wb_wr_q    <= wb_wr_d;
            wb_rw_q    <= wb_rw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_err_q   <= wb_err_d;
        end
    end

endmodule
